// File: rtl/uart_mem_ctrl_pkg.sv
// uart_mem_ctrl_pkg: state encoding, direction constants and helpers for uart_mem_ctrl
package uart_mem_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RX         = 3'd1,
        TX_RD      = 3'd2,
        TX_LAT     = 3'd3,
        TX_SEND    = 3'd4,
        TX_WAIT_HI = 3'd5,
        TX_WAIT_LO = 3'd6,
        DONE       = 3'd7
    } state_t;

    localparam logic MODE_RX = 1'b0;
    localparam logic MODE_TX = 1'b1;

    function automatic logic is_tx(input state_t s);
        return s inside {TX_RD, TX_LAT, TX_SEND, TX_WAIT_HI, TX_WAIT_LO};
    endfunction

endpackage

// File: rtl/uart_mem_ctrl.sv
// uart_mem_ctrl: moves bytes between a UART receiver/transmitter and a 1-cycle-latency memory
module uart_mem_ctrl
    import uart_mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              clk_50m,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    state_t            state, nxt;
    logic [ADDR_W-1:0] base_q, len_q, cnt;
    logic [ADDR_W-1:0] base_nxt, len_nxt, cnt_nxt, cnt_inc;
    logic              accept, wr_hit;

    assign cnt_inc = cnt + ADDR_W'(1);
    assign wr_hit  = (state == RX) && rx_valid;

    // next-state and transfer bookkeeping; abort wins over everything else
    always_comb begin
        nxt      = state;
        base_nxt = base_q;
        len_nxt  = len_q;
        cnt_nxt  = cnt;
        accept   = 1'b0;
        if (abort) begin
            nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (start) begin
                    accept   = 1'b1;
                    base_nxt = base_addr;
                    len_nxt  = length;
                    cnt_nxt  = '0;
                    nxt      = (length == '0) ? DONE : (mode == MODE_TX) ? TX_RD : RX;
                end
                RX: if (rx_valid) begin
                    cnt_nxt = cnt_inc;
                    nxt     = (cnt_inc == len_q) ? DONE : RX;
                end
                TX_RD:      nxt = TX_LAT;
                TX_LAT:     nxt = TX_SEND;
                TX_SEND:    nxt = tx_busy ? TX_SEND : TX_WAIT_HI;
                TX_WAIT_HI: nxt = tx_busy ? TX_WAIT_LO : TX_WAIT_HI;
                TX_WAIT_LO: if (!tx_busy) begin
                    cnt_nxt = cnt_inc;
                    nxt     = (cnt_inc == len_q) ? DONE : TX_RD;
                end
                default:    nxt = IDLE;
            endcase
        end
    end

    // state, latched transfer parameters and byte counter
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            state  <= IDLE;
            base_q <= '0;
            len_q  <= '0;
            cnt    <= '0;
        end else begin
            state  <= nxt;
            base_q <= base_nxt;
            len_q  <= len_nxt;
            cnt    <= cnt_nxt;
        end
    end

    // registered outputs; mem_re/mem_addr are loaded from the next state so the read is visible in TX_RD
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            overrun   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            tx_start  <= 1'b0;
            tx_data   <= '0;
        end else begin
            overrun <= accept ? 1'b0 : (is_tx(state) && rx_valid && !abort) ? 1'b1 : overrun;
            if (abort) begin
                busy      <= 1'b0;
                done      <= 1'b0;
                mem_we    <= 1'b0;
                mem_re    <= 1'b0;
                mem_addr  <= '0;
                mem_wdata <= '0;
                tx_start  <= 1'b0;
                tx_data   <= '0;
            end else begin
                busy      <= nxt != IDLE;
                done      <= state == DONE;
                mem_we    <= wr_hit;
                mem_re    <= nxt == TX_RD;
                mem_addr  <= wr_hit ? base_q + cnt : (nxt == TX_RD) ? base_nxt + cnt_nxt : mem_addr;
                mem_wdata <= wr_hit ? rx_data : mem_wdata;
                tx_start  <= (state == TX_SEND) && !tx_busy;
                tx_data   <= (state == TX_LAT) ? mem_rdata : tx_data;
            end
        end
    end

endmodule

// File: tb/tb_uart_mem_ctrl.sv
// tb_uart_mem_ctrl: scoreboard bench with memory and transmitter models
module tb_uart_mem_ctrl;
    import uart_mem_ctrl_pkg::*;

    logic        clk_50m = 1'b0;
    logic        rst = 1'b1, start = 1'b0, mode = 1'b0, abort = 1'b0, rx_valid = 1'b0;
    logic [15:0] base_addr = '0, length = '0;
    logic [7:0]  rx_data = '0;
    logic        tx_busy, tx_start, mem_we, mem_re, busy, done, overrun;
    logic [7:0]  tx_data, mem_wdata;
    logic [7:0]  mem_rdata = '0;
    logic [15:0] mem_addr;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t         exp_wr[$];
    logic [7:0]  exp_tx[$];
    int          checks = 0, failures = 0;
    int          done_cnt = 0, we_cnt = 0, ts_cnt = 0;
    logic [7:0]  mem [0:65535];
    logic        pre_we = 1'b0;
    logic [15:0] pre_addr = '0;
    logic [7:0]  pre_data = '0;
    int          busy_left = 0;

    always #10 clk_50m = ~clk_50m;

    uart_mem_ctrl dut (
        .clk_50m(clk_50m), .rst(rst), .start(start), .mode(mode), .abort(abort),
        .base_addr(base_addr), .length(length), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .busy(busy), .done(done), .overrun(overrun)
    );

    assign tx_busy = busy_left != 0;

    // memory with 1-cycle read latency and a transmitter busy for 10 cycles per byte
    always @(posedge clk_50m) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
        busy_left <= tx_start ? 10 : (busy_left > 0 ? busy_left - 1 : 0);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // scoreboard: compare every memory write and tx_start against the expected queues
    always @(negedge clk_50m) begin
        wr_t        w;
        logic [7:0] t;
        if (done) done_cnt++;
        if (mem_we) begin
            we_cnt++;
            if (exp_wr.size() == 0) check("wr_unexpected", 1, 0);
            else begin
                w = exp_wr.pop_front();
                check("wr_addr", {16'h0, mem_addr}, {16'h0, w.addr});
                check("wr_data", {24'h0, mem_wdata}, {24'h0, w.data});
            end
        end
        if (tx_start) begin
            ts_cnt++;
            if (exp_tx.size() == 0) check("tx_unexpected", 1, 0);
            else begin
                t = exp_tx.pop_front();
                check("tx_data", {24'h0, tx_data}, {24'h0, t});
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk_50m);
        #1;
    endtask

    task automatic start_xfer(input logic m, input logic [15:0] b, input logic [15:0] l);
        start = 1'b1; mode = m; base_addr = b; length = l;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d);
        rx_valid = 1'b1; rx_data = d;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        tick();
        pre_we = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0 = done_cnt;
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        check("done_seen", {31'h0, done_cnt != d0}, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog");
        $fatal(1);
    end

    initial begin
        int d0, w0, t0;
        tick(2);
        check("rst_ctl", {26'h0, busy, done, overrun, mem_we, mem_re, tx_start}, 0);
        check("rst_bus", {mem_addr, mem_wdata, tx_data}, 0);
        rst = 1'b0;
        tick();

        // RX of three bytes, with a second start while busy that must be ignored
        d0 = done_cnt;
        exp_wr.push_back('{16'h0010, 8'hA1});
        exp_wr.push_back('{16'h0011, 8'hB2});
        exp_wr.push_back('{16'h0012, 8'hC3});
        start_xfer(MODE_RX, 16'h0010, 16'd3);
        check("rx_busy", {31'h0, busy}, 1);
        start_xfer(MODE_TX, 16'h0200, 16'd0);
        send_byte(8'hA1);
        tick();
        send_byte(8'hB2);
        send_byte(8'hC3);
        wait_done(20);
        tick();
        check("rx_idle", {31'h0, busy}, 0);
        check("rx_wr_left", exp_wr.size(), 0);
        check("rx_done_once", done_cnt - d0, 1);

        // TX of two bytes, with a stray rx byte that must raise overrun
        preload(16'h0100, 8'h55);
        preload(16'h0101, 8'hAA);
        exp_tx.push_back(8'h55);
        exp_tx.push_back(8'hAA);
        t0 = ts_cnt;
        start_xfer(MODE_TX, 16'h0100, 16'd2);
        tick(4);
        send_byte(8'h77);
        check("ovr_set", {31'h0, overrun}, 1);
        wait_done(200);
        tick();
        check("tx_starts", ts_cnt - t0, 2);
        check("tx_left", exp_tx.size(), 0);
        check("ovr_hold", {31'h0, overrun}, 1);
        check("tx_idle", {31'h0, busy}, 0);

        // zero-length transfer: done two cycles after start, no activity, overrun cleared
        w0 = we_cnt; t0 = ts_cnt;
        start_xfer(MODE_RX, 16'h0040, 16'd0);
        check("len0_early", {31'h0, done}, 0);
        check("len0_ovr_clr", {31'h0, overrun}, 0);
        tick();
        check("len0_done", {31'h0, done}, 1);
        tick();
        check("len0_end", {30'h0, done, busy}, 0);
        check("len0_noact", (we_cnt - w0) + (ts_cnt - t0), 0);

        // address wrap past all-ones, back-to-back bytes
        exp_wr.push_back('{16'hFFFF, 8'h11});
        exp_wr.push_back('{16'h0000, 8'h22});
        start_xfer(MODE_RX, 16'hFFFF, 16'd2);
        send_byte(8'h11);
        send_byte(8'h22);
        wait_done(10);
        tick();
        check("wrap_left", exp_wr.size(), 0);

        // abort outranks start in the same cycle
        d0 = done_cnt;
        abort = 1'b1;
        start_xfer(MODE_RX, 16'h0050, 16'd1);
        abort = 1'b0;
        check("abort_vs_start", {31'h0, busy}, 0);

        // abort mid-RX after one of four bytes
        exp_wr.push_back('{16'h0300, 8'h01});
        start_xfer(MODE_RX, 16'h0300, 16'd4);
        send_byte(8'h01);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_ctl", {27'h0, busy, done, mem_we, mem_re, tx_start}, 0);
        check("abort_bus", {mem_addr, mem_wdata, tx_data}, 0);
        send_byte(8'h02);
        tick(3);
        check("abort_nodone", done_cnt - d0, 0);
        check("abort_wr_left", exp_wr.size(), 0);

        // reset mid-RX after one of four bytes
        d0 = done_cnt;
        exp_wr.push_back('{16'h0400, 8'h03});
        start_xfer(MODE_RX, 16'h0400, 16'd4);
        send_byte(8'h03);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstmid_ctl", {26'h0, busy, done, overrun, mem_we, mem_re, tx_start}, 0);
        check("rstmid_bus", {mem_addr, mem_wdata, tx_data}, 0);
        tick(3);
        check("rstmid_nodone", done_cnt - d0, 0);
        check("rstmid_wr_left", exp_wr.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
